// File: rtl/sc_lane_scheduler_pkg.sv
// rtl/sc_lane_scheduler_pkg.sv - shared state encodings and default constants for the lane scheduler
package sc_lanesched_defs;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_ACK = 2'd3
    } schedState_e;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_PRESCALE_W  = 25;
    localparam int DEF_LEVEL_W     = 2;
    localparam int DEF_BASE_PERIOD = 25000000;
    localparam int DEF_PERIOD_STEP = 5000000;
    localparam int DEF_MIN_PERIOD  = 2500000;
    localparam int ACK_TIMEOUT     = 255;

endpackage

// File: rtl/sc_lane_scheduler_if.sv
// rtl/sc_lane_scheduler_if.sv - game/lane-shifter handshake bundle seen by the lane scheduler
interface sc_lane_scheduler_if
    import sc_lanesched_defs::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int LEVEL_W   = DEF_LEVEL_W
);
    logic                 SC_LANESCHED_Run_InLow;
    logic                 SC_LANESCHED_LoadGame_InLow;
    logic [LEVEL_W-1:0]   SC_LANESCHED_Level_InBUS;
    logic                 SC_LANESCHED_ShiftAck_InLow;
    logic [NUM_LANES-1:0] SC_LANESCHED_Shift_OutBUS;
    logic                 SC_LANESCHED_Tick_OutLow;
    logic                 SC_LANESCHED_Busy_OutHigh;
    logic                 SC_LANESCHED_Error_OutHigh;

    modport master (
        output SC_LANESCHED_Run_InLow, SC_LANESCHED_LoadGame_InLow,
               SC_LANESCHED_Level_InBUS, SC_LANESCHED_ShiftAck_InLow,
        input  SC_LANESCHED_Shift_OutBUS, SC_LANESCHED_Tick_OutLow,
               SC_LANESCHED_Busy_OutHigh, SC_LANESCHED_Error_OutHigh
    );

    modport slave (
        input  SC_LANESCHED_Run_InLow, SC_LANESCHED_LoadGame_InLow,
               SC_LANESCHED_Level_InBUS, SC_LANESCHED_ShiftAck_InLow,
        output SC_LANESCHED_Shift_OutBUS, SC_LANESCHED_Tick_OutLow,
               SC_LANESCHED_Busy_OutHigh, SC_LANESCHED_Error_OutHigh
    );

endinterface

// File: rtl/sc_lane_scheduler_prescaler.sv
// rtl/sc_lane_scheduler_prescaler.sv - level-dependent move-period counter with terminal-count pulse
module sc_lanesched_prescaler
    import sc_lanesched_defs::*;
#(
    parameter int PRESCALE_W  = DEF_PRESCALE_W,
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [LEVEL_W-1:0] level,
    input  logic               load,
    input  logic               dec,
    output logic               tc
);
    localparam int CALC_W = PRESCALE_W + LEVEL_W;

    logic [CALC_W-1:0]     stepTotal;
    logic [CALC_W-1:0]     periodWide;
    logic [PRESCALE_W-1:0] periodVal;
    logic [PRESCALE_W-1:0] countReg;

    // Compare before subtracting so high levels clamp to the floor instead of wrapping.
    always_comb begin
        stepTotal  = CALC_W'(level) * CALC_W'(PERIOD_STEP);
        periodWide = CALC_W'(MIN_PERIOD);
        if (stepTotal < CALC_W'(BASE_PERIOD - MIN_PERIOD))
            periodWide = CALC_W'(BASE_PERIOD) - stepTotal;
    end

    assign periodVal = PRESCALE_W'(periodWide);
    assign tc        = dec && !load && (countReg == PRESCALE_W'(1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            countReg <= PRESCALE_W'(BASE_PERIOD);
        else if (load || tc)
            countReg <= periodVal;
        else if (dec)
            countReg <= countReg - PRESCALE_W'(1);
    end

endmodule

// File: rtl/sc_lane_scheduler.sv
// rtl/sc_lane_scheduler.sv - round-robin lane shift strobe sequencer; SC_LANESCHED_ACKTIMEOUT_EN adds ack timeout
module sc_lane_scheduler
    import sc_lanesched_defs::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int PRESCALE_W  = DEF_PRESCALE_W,
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
    input  logic                SC_LANESCHED_CLOCK_50,
    input  logic                SC_LANESCHED_RESET_InLow,
    sc_lane_scheduler_if.slave  laneBus
);
    localparam int IDX_W = $clog2(NUM_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    schedState_e          stateReg, stateNext;
    logic [IDX_W-1:0]     laneIdx, laneIdxNext;
    logic                 loadPending;
    logic                 inRound, laneDone, lastDone, timeoutHit;
    logic                 prescaleLoad, prescaleDec, prescaleTc;
    logic [NUM_LANES-1:0] shiftBus;

    assign inRound  = (stateReg == ISSUE) || (stateReg == WAIT_ACK);
    assign laneDone = (stateReg == WAIT_ACK) && (!laneBus.SC_LANESCHED_ShiftAck_InLow || timeoutHit);
    assign lastDone = laneDone && (laneIdx == LAST_IDX);

    // IDLE keeps loading so the first COUNT entry starts from period(Level).
    assign prescaleLoad = (stateReg == IDLE)
                       || ((stateReg == COUNT) && !laneBus.SC_LANESCHED_LoadGame_InLow)
                       || (lastDone && (loadPending || !laneBus.SC_LANESCHED_LoadGame_InLow));
    assign prescaleDec  = (stateReg == COUNT) && !laneBus.SC_LANESCHED_Run_InLow;

    sc_lanesched_prescaler #(
        .PRESCALE_W  (PRESCALE_W),
        .LEVEL_W     (LEVEL_W),
        .BASE_PERIOD (BASE_PERIOD),
        .PERIOD_STEP (PERIOD_STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_prescaler (
        .clk   (SC_LANESCHED_CLOCK_50),
        .rstN  (SC_LANESCHED_RESET_InLow),
        .level (laneBus.SC_LANESCHED_Level_InBUS),
        .load  (prescaleLoad),
        .dec   (prescaleDec),
        .tc    (prescaleTc)
    );

    always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET_InLow) begin
        if (!SC_LANESCHED_RESET_InLow) begin
            stateReg    <= IDLE;
            laneIdx     <= '0;
            loadPending <= 1'b0;
        end else begin
            stateReg <= stateNext;
            laneIdx  <= laneIdxNext;
            if (lastDone)
                loadPending <= 1'b0;
            else if (inRound && !laneBus.SC_LANESCHED_LoadGame_InLow)
                loadPending <= 1'b1;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        laneIdxNext = laneIdx;
        case (stateReg)
            IDLE:     if (!laneBus.SC_LANESCHED_Run_InLow) stateNext = COUNT;
            COUNT:    if (prescaleTc) begin
                          stateNext   = ISSUE;
                          laneIdxNext = '0;
                      end
            ISSUE:    stateNext = WAIT_ACK;
            WAIT_ACK: if (laneDone) begin
                          if (laneIdx == LAST_IDX) begin
                              stateNext = COUNT;
                          end else begin
                              stateNext   = ISSUE;
                              laneIdxNext = laneIdx + IDX_W'(1);
                          end
                      end
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        shiftBus = '1;
        if (inRound)
            shiftBus[laneIdx] = 1'b0;
    end

    assign laneBus.SC_LANESCHED_Shift_OutBUS = shiftBus;
    assign laneBus.SC_LANESCHED_Tick_OutLow  = !((stateReg == ISSUE) && (laneIdx == '0));
    assign laneBus.SC_LANESCHED_Busy_OutHigh = inRound;

`ifdef SC_LANESCHED_ACKTIMEOUT_EN
    logic [7:0] ackTimer;
    logic       errorFlag;

    assign timeoutHit = (stateReg == WAIT_ACK) && (ackTimer == 8'(ACK_TIMEOUT));

    always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET_InLow) begin
        if (!SC_LANESCHED_RESET_InLow) begin
            ackTimer  <= 8'd0;
            errorFlag <= 1'b0;
        end else begin
            ackTimer <= ((stateReg == WAIT_ACK) && !laneDone) ? ackTimer + 8'd1 : 8'd0;
            if (timeoutHit && laneBus.SC_LANESCHED_ShiftAck_InLow)
                errorFlag <= 1'b1;
        end
    end

    assign laneBus.SC_LANESCHED_Error_OutHigh = errorFlag;
`else
    assign timeoutHit                         = 1'b0;
    assign laneBus.SC_LANESCHED_Error_OutHigh = 1'b0;
`endif

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// tb/tb_sc_lane_scheduler.sv - directed scoreboard bench for sc_lane_scheduler (SC_LANESCHED_ACKTIMEOUT_EN section optional)
module tb_sc_lane_scheduler;

    logic clk50;
    logic resetN;
    int   assertCount;
    int   failCount;
    logic skipLane2;
    logic [3:0] shiftQ[$];

    sc_lane_scheduler_if #(.NUM_LANES(4), .LEVEL_W(2)) bus ();
    sc_lane_scheduler_if #(.NUM_LANES(4), .LEVEL_W(2)) satBus ();

    sc_lane_scheduler #(
        .NUM_LANES(4), .PRESCALE_W(25), .LEVEL_W(2),
        .BASE_PERIOD(20), .PERIOD_STEP(4), .MIN_PERIOD(6)
    ) dut (
        .SC_LANESCHED_CLOCK_50    (clk50),
        .SC_LANESCHED_RESET_InLow (resetN),
        .laneBus                  (bus.slave)
    );

    // Steeper step so level 3 falls below the floor and must clamp to 6.
    sc_lane_scheduler #(
        .NUM_LANES(4), .PRESCALE_W(25), .LEVEL_W(2),
        .BASE_PERIOD(20), .PERIOD_STEP(8), .MIN_PERIOD(6)
    ) dutSat (
        .SC_LANESCHED_CLOCK_50    (clk50),
        .SC_LANESCHED_RESET_InLow (resetN),
        .laneBus                  (satBus.slave)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    task automatic check(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic expectRound();
        shiftQ.push_back(4'b1110);
        shiftQ.push_back(4'b1101);
        shiftQ.push_back(4'b1011);
        shiftQ.push_back(4'b0111);
    endtask

    task automatic waitTick(input int bound, output int elapsed);
        elapsed = -1;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk50);
            if (bus.SC_LANESCHED_Tick_OutLow === 1'b0) begin
                elapsed = n;
                break;
            end
        end
    endtask

    task automatic waitBusyLow(input int bound, output int elapsed);
        elapsed = -1;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk50);
            if (bus.SC_LANESCHED_Busy_OutHigh === 1'b0) begin
                elapsed = n;
                break;
            end
        end
    endtask

    // Lane shifter model: acks each new strobe two cycles after it appears; checks strobes against the scoreboard.
    initial begin
        logic [3:0] prevShift;
        logic [3:0] curr;
        int         ackCnt;
        prevShift = 4'hF;
        ackCnt    = 0;
        bus.SC_LANESCHED_ShiftAck_InLow = 1'b1;
        forever begin
            @(negedge clk50);
            bus.SC_LANESCHED_ShiftAck_InLow = 1'b1;
            if (!resetN) begin
                prevShift = 4'hF;
                ackCnt    = 0;
            end else begin
                curr = bus.SC_LANESCHED_Shift_OutBUS;
                if (ackCnt == 2) begin
                    bus.SC_LANESCHED_ShiftAck_InLow = 1'b0;
                    ackCnt = 0;
                end else if (ackCnt == 1) begin
                    ackCnt = 2;
                end
                if (curr != 4'hF && curr != prevShift) begin
                    check("strobe_expected", int'(shiftQ.size() > 0), 1);
                    if (shiftQ.size() > 0)
                        check("shift_pattern", int'(curr), int'(shiftQ.pop_front()));
                    if (!(skipLane2 && curr == 4'b1011))
                        ackCnt = 1;
                end
                prevShift = curr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int el;
        int mainTicks;
        int busyHigh;
        int satFirst;
        int satSecond;
        assertCount = 0;
        failCount   = 0;
        skipLane2   = 1'b0;
        resetN      = 1'b0;
        bus.SC_LANESCHED_Run_InLow      = 1'b1;
        bus.SC_LANESCHED_LoadGame_InLow = 1'b1;
        bus.SC_LANESCHED_Level_InBUS    = 2'd0;
        satBus.SC_LANESCHED_Run_InLow      = 1'b0;
        satBus.SC_LANESCHED_LoadGame_InLow = 1'b1;
        satBus.SC_LANESCHED_Level_InBUS    = 2'd3;
        satBus.SC_LANESCHED_ShiftAck_InLow = 1'b0;

        repeat (3) @(negedge clk50);
        check("rst_shift", int'(bus.SC_LANESCHED_Shift_OutBUS), 15);
        check("rst_tick",  int'(bus.SC_LANESCHED_Tick_OutLow), 1);
        check("rst_busy",  int'(bus.SC_LANESCHED_Busy_OutHigh), 0);
        check("rst_error", int'(bus.SC_LANESCHED_Error_OutHigh), 0);

        // One IDLE cycle, then a full 20-cycle level-0 period.
        expectRound();
        resetN = 1'b1;
        bus.SC_LANESCHED_Run_InLow = 1'b0;
        waitTick(100, el);
        check("first_tick", el, 21);
        check("busy_at_tick", int'(bus.SC_LANESCHED_Busy_OutHigh), 1);
        busyHigh = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk50);
            if (bus.SC_LANESCHED_Busy_OutHigh === 1'b1) busyHigh++;
        end
        check("busy_whole_round", busyHigh, 11);
        waitBusyLow(50, el);
        check("round_len", el, 1);

        // Level raised mid-count only applies at the following reload.
        bus.SC_LANESCHED_Level_InBUS = 2'd3;
        expectRound();
        waitTick(100, el);
        check("tick_lvl0_after_change", el, 20);
        waitBusyLow(50, el);
        check("round_len_b", el, 12);
        bus.SC_LANESCHED_Level_InBUS = 2'd0;
        expectRound();
        waitTick(100, el);
        check("tick_lvl3", el, 8);
        waitBusyLow(50, el);
        check("round_len_c", el, 12);

        // Pause for 10 cycles with the prescaler at 12.
        repeat (8) @(negedge clk50);
        bus.SC_LANESCHED_Run_InLow = 1'b1;
        repeat (10) @(negedge clk50);
        bus.SC_LANESCHED_Run_InLow = 1'b0;
        expectRound();
        waitTick(100, el);
        check("tick_after_pause", el, 12);

        // Pause mid-round: the round still completes, then counting holds.
        bus.SC_LANESCHED_Run_InLow = 1'b1;
        waitBusyLow(50, el);
        check("round_len_paused", el, 12);
        mainTicks = 0;
        busyHigh  = 0;
        satFirst  = -1;
        satSecond = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk50);
            if (bus.SC_LANESCHED_Tick_OutLow === 1'b0) mainTicks++;
            if (bus.SC_LANESCHED_Busy_OutHigh === 1'b1) busyHigh++;
            if (satBus.SC_LANESCHED_Tick_OutLow === 1'b0) begin
                if (satFirst < 0) satFirst = i;
                else if (satSecond < 0) satSecond = i;
            end
        end
        check("paused_no_tick", mainTicks, 0);
        check("paused_not_busy", busyHigh, 0);
        check("sat_tick_seen", int'(satSecond > 0), 1);
        check("sat_tick_gap", satSecond - satFirst, 14);
        bus.SC_LANESCHED_Run_InLow = 1'b0;
        expectRound();
        waitTick(100, el);
        check("tick_after_resume", el, 20);

        // LoadGame at count 5 reloads the full period.
        waitBusyLow(50, el);
        check("round_len_d", el, 12);
        repeat (15) @(negedge clk50);
        bus.SC_LANESCHED_LoadGame_InLow = 1'b0;
        @(negedge clk50);
        bus.SC_LANESCHED_LoadGame_InLow = 1'b1;
        expectRound();
        waitTick(100, el);
        check("tick_after_load", el, 20);

        // LoadGame during WAIT_ACK: reload deferred to round end, picking up the new level.
        bus.SC_LANESCHED_Level_InBUS = 2'd3;
        @(negedge clk50);
        bus.SC_LANESCHED_LoadGame_InLow = 1'b0;
        @(negedge clk50);
        bus.SC_LANESCHED_LoadGame_InLow = 1'b1;
        waitBusyLow(50, el);
        check("round_len_load", el, 10);
        expectRound();
        waitTick(100, el);
        check("tick_pending_reload", el, 8);

        // Async reset with lane 1 strobed.
        repeat (3) @(negedge clk50);
        check("mid_round_shift", int'(bus.SC_LANESCHED_Shift_OutBUS), 13);
        #2 resetN = 1'b0;
        #1;
        check("async_rst_shift", int'(bus.SC_LANESCHED_Shift_OutBUS), 15);
        check("async_rst_tick",  int'(bus.SC_LANESCHED_Tick_OutLow), 1);
        check("async_rst_busy",  int'(bus.SC_LANESCHED_Busy_OutHigh), 0);
        shiftQ.delete();
        bus.SC_LANESCHED_Level_InBUS = 2'd0;
        repeat (2) @(negedge clk50);
        expectRound();
        resetN = 1'b1;
        waitTick(100, el);
        check("tick_after_reset", el, 21);
        waitBusyLow(50, el);
        check("round_len_e", el, 12);

`ifdef SC_LANESCHED_ACKTIMEOUT_EN
        skipLane2 = 1'b1;
        expectRound();
        waitTick(100, el);
        check("timeout_round_tick", el, 20);
        el = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk50);
            if (bus.SC_LANESCHED_Error_OutHigh === 1'b1) begin
                el = n;
                break;
            end
        end
        check("timeout_error_seen", int'(el > 0), 1);
        check("timeout_next_lane", int'(bus.SC_LANESCHED_Shift_OutBUS), 7);
        skipLane2 = 1'b0;
        waitBusyLow(50, el);
        check("timeout_round_end", int'(el > 0), 1);
        repeat (5) @(negedge clk50);
        check("timeout_error_sticky", int'(bus.SC_LANESCHED_Error_OutHigh), 1);
`else
        check("error_tied_low", int'(bus.SC_LANESCHED_Error_OutHigh), 0);
`endif

        check("scoreboard_drained", shiftQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
